uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//   Consumes the byte strobe stream from the UART receiver and assembles fixed-length
//   command frames for the DRAM test engine. Checks a checksum and emits one command
//   on a valid/ready handshake. Reports framing, drop and timeout errors as 1-cycle pulses.
//   Sits between the UART RX stage and the command consumer. The RX stage has no backpressure.
// PARAMETERS
//   SYNC_BYTE    8'hA5      frame start marker
//   TIMEOUT_CYC  1_000_000  inter-byte timeout in clk cycles (10 ms @ 100 MHz); must be >=1
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   rx_stb       in   1   1-cycle strobe: rx_data valid
//   rx_data      in   8   received byte
//   cmd_valid    out  1   command available
//   cmd_ready    in   1   consumer accepts command
//   cmd_op       out  8   opcode
//   cmd_addr     out  32  address
//   cmd_wdata    out  32  write data
//   err_csum     out  1   1-cycle pulse: checksum mismatch, frame discarded
//   err_drop     out  1   1-cycle pulse: byte discarded while a command was pending
//   err_timeout  out  1   1-cycle pulse: frame abandoned on inter-byte timeout
//   busy         out  1   high in every state except IDLE
// BEHAVIOUR
//   - Frame (11 bytes): SYNC, OP, ADDR[31:24..7:0], WDATA[31:24..7:0], CSUM. Multi-byte fields MSB first.
//   - CSUM = XOR of the 9 bytes OP..WDATA[7:0]. SYNC is not included.
//   - Reset: state IDLE; byte counter 0; every output 0, including cmd_op, cmd_addr and cmd_wdata.
//   - States:
//       IDLE  rx_stb & rx_data==SYNC_BYTE -> OP; other bytes are ignored silently.
//       OP    next byte -> cmd_op; state -> ADDR.
//       ADDR  4 bytes, 2-bit counter; after the 4th byte -> DATA.
//       DATA  4 bytes; after the 4th byte -> CSUM.
//       CSUM  byte == running XOR -> HOLD, cmd_valid=1 on the next cycle.
//             Mismatch -> err_csum=1 for one cycle; state -> IDLE.
//       HOLD  cmd_valid held high; cmd_op, cmd_addr, cmd_wdata held stable.
//             A transfer happens on a clk edge where cmd_valid & cmd_ready.
//             After the transfer: cmd_valid=0 on the next cycle; state -> IDLE.
//   - Latency: cmd_valid rises exactly 1 cycle after the edge that samples the CSUM strobe.
//   - cmd_ready is ignored outside HOLD. It may be tied high: the minimum valid pulse is 1 cycle.
//   - Drops: an rx_stb in HOLD, including the transfer cycle itself, discards the byte.
//     err_drop=1 for one cycle. The command is unaffected.
//   - A SYNC_BYTE value inside the frame body is data. There is no resync within a frame.
//   - The running XOR is cleared on entry to OP.
//   - Field registers update only while a frame is being assembled. They never change while cmd_valid=1.
//   - Error pulses are mutually exclusive per cycle. They are registered: 1 cycle after the causing strobe.
//   - rst mid-frame or in HOLD: abort immediately. No pulse and no command; the next frame parses normally.
// CONFIGURATION
//   CMD_PARSER_TIMEOUT_EN defined:
//     - Counter width $clog2(TIMEOUT_CYC+1). It is cleared on every rx_stb and runs only in OP..CSUM.
//     - When TIMEOUT_CYC cycles elapse with no strobe: err_timeout=1 for one cycle; state -> IDLE;
//       partial fields are discarded.
//     - A strobe in the same cycle the limit is reached wins: the byte is accepted and there is no timeout.
//   CMD_PARSER_TIMEOUT_EN undefined:
//     - No counter logic. err_timeout is tied 0.
//     - A partial frame waits indefinitely for its remaining bytes.
// TESTING
//   T1 Valid frame: A5 01 00 00 10 00 DE AD BE EF 33, cmd_ready=1.
//      -> One cmd_valid with op=01, addr=0000_1000, wdata=DEAD_BEEF; no error pulses.
//   T2 Bad checksum: same frame with CSUM=34.
//      -> err_csum pulses once; no cmd_valid; next good frame is accepted.
//   T3 Backpressure: hold cmd_ready=0 for 50 cycles after T1 completes, inject byte 55.
//      -> err_drop pulses once; fields stable; ready=1 gives exactly one transfer.
//   T4 Garbage before frame: 00 FF 5A, then the T1 frame.
//      -> Exactly one command with T1 values; no errors.
//   T5 Timeout (TIMEOUT_CYC=100, macro on): A5 01, then stall 100 cycles.
//      -> err_timeout pulses, busy=0, then the T1 frame succeeds.
//      Macro off: resuming 00 00 10 00 DE AD BE EF 33 completes the command.
//   T6 rst for 1 cycle after the 5th byte of T1.
//      -> All outputs 0, busy=0; a subsequent full T1 frame yields one command.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte-in / command-out signal bundle for uart_cmd_parser
//
// Groups the receive byte strobe, the command handshake and the status pulses.
//   master : the parser side (consumes rx_*, cmd_ready; drives cmd_*, err_*, busy)
//   slave  : the environment side (UART RX stage plus command consumer)
//
//   rx_stb       1   1-cycle strobe: rx_data valid
//   rx_data      8   received byte
//   cmd_valid    1   command available
//   cmd_ready    1   consumer accepts command
//   cmd_op       8   opcode
//   cmd_addr     32  address
//   cmd_wdata    32  write data
//   err_csum     1   pulse: checksum mismatch, frame discarded
//   err_drop     1   pulse: byte discarded while a command was pending
//   err_timeout  1   pulse: frame abandoned on inter-byte timeout
//   busy         1   parser is not idle
interface uart_cmd_parser_if;
  logic        rx_stb;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err_csum;
  logic        err_drop;
  logic        err_timeout;
  logic        busy;

  modport master (
    input  rx_stb, rx_data, cmd_ready,
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
           err_csum, err_drop, err_timeout, busy
  );

  modport slave (
    output rx_stb, rx_data, cmd_ready,
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
           err_csum, err_drop, err_timeout, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles checksummed 11-byte command frames from a UART byte stream
//
// Frame: SYNC, OP, ADDR[31:24]..ADDR[7:0], WDATA[31:24]..WDATA[7:0], CSUM (multi-byte fields
// MSB first). CSUM is the XOR of the nine bytes OP..WDATA[7:0]. A good frame is presented on
// a valid/ready handshake; error conditions are reported as registered 1-cycle pulses.
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active-high; aborts any frame or pending command
//   bus   uart_cmd_parser_if.master (rx_stb/rx_data in, cmd_* handshake, err_* pulses, busy)
//
// Parameters:
//   SYNC_BYTE    frame start marker
//   TIMEOUT_CYC  inter-byte timeout in clk cycles (>= 1)
//
// Build option: define CMD_PARSER_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYC
// strobe-free cycles; without it err_timeout is tied low and a partial frame waits forever.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_parser_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [7:0]  csum_acc, csum_nxt;
  logic [7:0]  op_q, op_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        err_csum_q, err_csum_nxt;
  logic        err_drop_q, err_drop_nxt;
  logic        err_timeout_q, err_timeout_nxt;
  logic        in_hold;
  logic        tmo_hit;

  assign in_hold = (state == S_HOLD);

`ifdef CMD_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = (state == S_OP) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CSUM);

  // Counts strobe-free cycles since the last accepted byte. Firing on the
  // TIMEOUT_CYC-th empty cycle means a strobe landing on that same cycle
  // clears the count instead and wins.
  assign tmo_hit = in_frame && !bus.rx_stb && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || bus.rx_stb || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  // Counter compiled out; the expression only keeps TIMEOUT_CYC referenced.
  assign tmo_hit = (TIMEOUT_CYC == 0) && 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      csum_acc      <= '0;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      err_csum_q    <= 1'b0;
      err_drop_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      byte_cnt      <= byte_cnt_nxt;
      csum_acc      <= csum_nxt;
      op_q          <= op_nxt;
      addr_q        <= addr_nxt;
      wdata_q       <= wdata_nxt;
      err_csum_q    <= err_csum_nxt;
      err_drop_q    <= err_drop_nxt;
      err_timeout_q <= err_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    byte_cnt_nxt    = byte_cnt;
    csum_nxt        = csum_acc;
    op_nxt          = op_q;
    addr_nxt        = addr_q;
    wdata_nxt       = wdata_q;
    err_csum_nxt    = 1'b0;
    err_drop_nxt    = 1'b0;
    err_timeout_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.rx_stb && (bus.rx_data == SYNC_BYTE)) begin
          state_nxt    = S_OP;
          csum_nxt     = '0;
          byte_cnt_nxt = '0;
        end
      end

      S_OP: begin
        if (bus.rx_stb) begin
          op_nxt    = bus.rx_data;
          csum_nxt  = csum_acc ^ bus.rx_data;
          state_nxt = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus.rx_stb) begin
          addr_nxt     = {addr_q[23:0], bus.rx_data};
          csum_nxt     = csum_acc ^ bus.rx_data;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bus.rx_stb) begin
          wdata_nxt    = {wdata_q[23:0], bus.rx_data};
          csum_nxt     = csum_acc ^ bus.rx_data;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_nxt = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (bus.rx_stb) begin
          if (bus.rx_data == csum_acc) begin
            state_nxt = S_HOLD;
          end else begin
            err_csum_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end
        end
      end

      S_HOLD: begin
        // The RX stage cannot be stalled, so any byte arriving while the
        // command waits is lost, including on the transfer cycle itself.
        if (bus.rx_stb) begin
          err_drop_nxt = 1'b1;
        end
        if (bus.cmd_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (tmo_hit) begin
      state_nxt       = S_IDLE;
      byte_cnt_nxt    = '0;
      err_timeout_nxt = 1'b1;
    end
  end

  assign bus.cmd_valid   = in_hold;
  assign bus.cmd_op      = op_q;
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_wdata   = wdata_q;
  assign bus.err_csum    = err_csum_q;
  assign bus.err_drop    = err_drop_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed and randomized self-checking bench for uart_cmd_parser
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int unsigned TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_csum, n_drop, n_tmo, n_multi, n_unstable;
  logic [71:0] got_q[$];
  logic [71:0] exp_q[$];
  logic [71:0] held;
  logic        prev_valid;
  bit          rand_ready;
  logic [7:0]  fb[11];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, log a transfer if the handshake completes
  // on this edge, then observe the registered outputs 1 ns after the edge.
  task automatic step(input logic stb, input logic [7:0] d);
    bus.rx_stb  = stb;
    bus.rx_data = d;
    if (rand_ready) bus.cmd_ready = 1'($urandom_range(0, 1));
    if (!rst && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1)
      got_q.push_back({bus.cmd_op, bus.cmd_addr, bus.cmd_wdata});
    @(posedge clk);
    #1;
    bus.rx_stb = 1'b0;
    if (bus.err_csum === 1'b1) n_csum++;
    if (bus.err_drop === 1'b1) n_drop++;
    if (bus.err_timeout === 1'b1) n_tmo++;
    if ((int'(bus.err_csum) + int'(bus.err_drop) + int'(bus.err_timeout)) > 1) n_multi++;
    if (bus.cmd_valid === 1'b1 && prev_valid &&
        {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== held) n_unstable++;
    held       = {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata};
    prev_valid = (bus.cmd_valid === 1'b1);
  endtask

  task automatic clear_counts();
    n_csum = 0; n_drop = 0; n_tmo = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;
    prev_valid = 1'b0;
  endtask

  // Builds the byte image of a frame; a bad frame gets CSUM one above the true XOR.
  task automatic build(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit bad);
    logic [7:0] x;
    fb[0] = 8'hA5;
    fb[1] = op;
    for (int i = 0; i < 4; i++) begin
      fb[2 + i] = addr[31 - 8*i -: 8];
      fb[6 + i] = wdata[31 - 8*i -: 8];
    end
    x = 8'h00;
    for (int i = 1; i < 10; i++) x = x ^ fb[i];
    fb[10] = bad ? x + 8'd1 : x;
    if (!bad) exp_q.push_back({op, addr, wdata});
  endtask

  // gap < 0 picks a random 0..3 idle cycles between bytes.
  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit bad, input int gap);
    build(op, addr, wdata, bad);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, fb[i]);
      if (i != 10) begin
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int j = 0; j < g; j++) step(1'b0, 8'h00);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int start;
    int n;
    start = got_q.size();
    n = 0;
    while (got_q.size() == start && n < budget) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk(tag, 72'(got_q.size() > start), 72'd1);
  endtask

  task automatic check_cmds(input string tag);
    chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_cmd"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk(tag, {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, bus.err_csum,
              bus.err_drop, bus.err_timeout, bus.busy}, '0);
  endtask

  initial begin
    int k;
    bit seen;
    int exp_csum_errs;

    bus.rx_stb    = 1'b0;
    bus.rx_data   = 8'h00;
    bus.cmd_ready = 1'b0;
    rand_ready    = 1'b0;
    n_multi       = 0;
    n_unstable    = 0;
    prev_valid    = 1'b0;
    held          = '0;
    clear_counts();

    do_reset();
    chk_idle_zero("reset_outputs");

    // T1: valid frame, ready tied high, valid one cycle after the CSUM edge.
    bus.cmd_ready = 1'b1;
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 0);
    chk("t1_csum_byte", 72'(fb[10]), 72'h33);
    chk("t1_valid_latency", 72'(bus.cmd_valid), 72'd1);
    chk("t1_fields", {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata}, {8'h01, 32'h0000_1000, 32'hDEAD_BEEF});
    step(1'b0, 8'h00);
    chk("t1_valid_drop", {72'(bus.cmd_valid), 72'(bus.busy)} != '0, 72'd0);
    check_cmds("t1");
    chk("t1_errs", 72'(n_csum + n_drop + n_tmo), 72'd0);

    // T2: bad checksum pulses err_csum in the cycle after the CSUM strobe.
    clear_counts();
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1);
    chk("t2_err_csum_now", 72'(bus.err_csum), 72'd1);
    chk("t2_busy", 72'(bus.busy), 72'd0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("t2_err_csum_count", 72'(n_csum), 72'd1);
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 0);
    drain("t2_drain", 20);
    check_cmds("t2");

    // T3: backpressure with a dropped byte, then drop on the transfer cycle.
    clear_counts();
    bus.cmd_ready = 1'b0;
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 0);
    for (int i = 0; i < 50; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h55);
    chk("t3_err_drop_now", 72'(bus.err_drop), 72'd1);
    step(1'b0, 8'h00);
    chk("t3_still_valid", 72'(bus.cmd_valid), 72'd1);
    chk("t3_fields", {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata}, {8'h01, 32'h0000_1000, 32'hDEAD_BEEF});
    chk("t3_no_early_xfer", 72'(got_q.size()), 72'd0);
    bus.cmd_ready = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("t3_drop_count", 72'(n_drop), 72'd1);
    check_cmds("t3");
    send_frame(8'h7E, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);
    step(1'b1, 8'h66);
    chk("t3_xfer_cycle_drop", 72'(bus.err_drop), 72'd1);
    chk("t3_xfer_cycle_valid", 72'(bus.cmd_valid), 72'd0);
    check_cmds("t3b");

    // T4: garbage before the frame, and SYNC values inside the body.
    clear_counts();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h5A);
    chk("t4_garbage_idle", 72'(bus.busy), 72'd0);
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 0);
    drain("t4_drain", 20);
    send_frame(8'hA5, 32'hA5A5_A5A5, 32'h00A5_A500, 1'b0, 2);
    drain("t4_sync_body_drain", 20);
    check_cmds("t4");
    chk("t4_errs", 72'(n_csum + n_drop + n_tmo), 72'd0);

    // T5: inter-byte timeout behaviour.
    clear_counts();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
`ifdef CMD_PARSER_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    while (!seen && k < 3 * TMO) begin
      step(1'b0, 8'h00);
      k++;
      if (bus.err_timeout === 1'b1) seen = 1'b1;
    end
    chk("t5_tmo_cycle", 72'(k), 72'(TMO));
    chk("t5_busy_after", 72'(bus.busy), 72'd0);
    step(1'b0, 8'h00);
    chk("t5_tmo_count", 72'(n_tmo), 72'd1);
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 0);
    drain("t5_drain", 20);
    send_frame(8'h42, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0, int'(TMO) - 1);
    drain("t5_edge_drain", 20);
    chk("t5_edge_no_tmo", 72'(n_tmo), 72'd1);
    check_cmds("t5");
`else
    for (int i = 0; i < 3 * int'(TMO); i++) step(1'b0, 8'h00);
    chk("t5_still_busy", 72'(bus.busy), 72'd1);
    chk("t5_no_tmo", 72'(n_tmo), 72'd0);
    build(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    for (int i = 2; i < 11; i++) step(1'b1, fb[i]);
    drain("t5_resume_drain", 20);
    check_cmds("t5");
`endif

    // T6: reset after the 5th byte aborts silently; next frame parses.
    clear_counts();
    build(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, fb[i]);
    chk("t6_busy_mid", 72'(bus.busy), 72'd1);
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
    prev_valid = 1'b0;
    chk_idle_zero("t6_after_rst");
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 0);
    drain("t6_drain", 20);
    check_cmds("t6");
    chk("t6_errs", 72'(n_csum + n_drop + n_tmo), 72'd0);

    // Randomized frames with random gaps, garbage, bad checksums and ready.
    clear_counts();
    exp_csum_errs = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int ng;
      bit bad;
      ng = int'($urandom_range(0, 3));
      for (int g = 0; g < ng; g++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h5A;
        step(1'b1, gb);
      end
      bad = ($urandom_range(0, 3) == 0);
      send_frame(8'($urandom), 32'($urandom), 32'($urandom), bad, -1);
      if (bad) begin
        exp_csum_errs++;
        step(1'b0, 8'h00);
      end else begin
        drain("rnd_drain", 200);
      end
    end
    rand_ready = 1'b0;
    bus.cmd_ready = 1'b1;
    step(1'b0, 8'h00);
    check_cmds("rnd");
    chk("rnd_csum_errs", 72'(n_csum), 72'(exp_csum_errs));
    chk("rnd_drop_tmo", 72'(n_drop + n_tmo), 72'd0);

    chk("err_exclusive", 72'(n_multi), 72'd0);
    chk("fields_stable", 72'(n_unstable), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
